// File: rtl/day_night_detector_if.sv
// Sensor-sample stream into the day/night detector and the debounced day level out of it.
interface day_night_detector_if #(
    parameter int DATA_W = 8
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              day;
    logic              day_change;

    modport master (
        output sample_valid,
        output sample,
        input  day,
        input  day_change
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output day,
        output day_change
    );
endinterface

// File: rtl/day_night_detector.sv
// 4-sample moving average, hysteresis classification and debounce producing traffic_timer's day level.
// Optional DAYNIGHT_FORCE_EN adds force_en/force_day override inputs.
//
// state    | meaning
// NIGHT    | day=0, stable
// TO_DAY   | day=0, counting consecutive HI samples
// DAY      | day=1, stable
// TO_NIGHT | day=1, counting consecutive LO samples
module day_night_detector #(
    parameter int DATA_W       = 8,
    parameter int DAY_THRESH   = 160,
    parameter int NIGHT_THRESH = 96,
    parameter int HOLD_SAMPLES = 4,
    parameter int CNT_W        = 4
) (
    input logic clk,
    input logic reset,
`ifdef DAYNIGHT_FORCE_EN
    input logic force_en,
    input logic force_day,
`endif
    day_night_detector_if.slave bus
);

    typedef enum logic [1:0] {
        NIGHT    = 2'd0,
        TO_DAY   = 2'd1,
        DAY      = 2'd2,
        TO_NIGHT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  HOLD_CNT = CNT_W'(HOLD_SAMPLES);
    localparam logic [DATA_W-1:0] HI_LVL   = DATA_W'(DAY_THRESH);
    localparam logic [DATA_W-1:0] LO_LVL   = DATA_W'(NIGHT_THRESH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              day_q;
    logic              day_change_q;
    // The oldest of the four entries always falls out on a shift, so only three are kept.
    logic [DATA_W-1:0] hist0, hist1, hist2;

    logic [DATA_W+1:0] sum;
    logic [DATA_W-1:0] avg;
    logic              is_hi;
    logic              is_lo;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        sum     = {2'b00, bus.sample} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
        avg     = sum[DATA_W+1:2];
        is_hi   = (avg >= HI_LVL);
        is_lo   = (avg <= LO_LVL);
        cnt_inc = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist0        <= '0;
            hist1        <= '0;
            hist2        <= '0;
            state        <= NIGHT;
            cnt          <= '0;
            day_q        <= 1'b0;
            day_change_q <= 1'b0;
        end else begin
            day_change_q <= 1'b0;
            if (bus.sample_valid) begin
                hist0 <= bus.sample;
                hist1 <= hist0;
                hist2 <= hist1;
            end
`ifdef DAYNIGHT_FORCE_EN
            if (force_en) begin
                state        <= force_day ? DAY : NIGHT;
                cnt          <= '0;
                day_q        <= force_day;
                day_change_q <= (force_day != day_q);
            end else
`endif
            if (bus.sample_valid) begin
                case (state)
                    NIGHT: begin
                        if (is_hi) begin
                            if (HOLD_SAMPLES == 1) begin
                                state        <= DAY;
                                day_q        <= 1'b1;
                                day_change_q <= 1'b1;
                            end else begin
                                state <= TO_DAY;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    TO_DAY: begin
                        if (is_hi) begin
                            if (cnt_inc == HOLD_CNT) begin
                                state        <= DAY;
                                cnt          <= '0;
                                day_q        <= 1'b1;
                                day_change_q <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= NIGHT;
                            cnt   <= '0;
                        end
                    end
                    DAY: begin
                        if (is_lo) begin
                            if (HOLD_SAMPLES == 1) begin
                                state        <= NIGHT;
                                day_q        <= 1'b0;
                                day_change_q <= 1'b1;
                            end else begin
                                state <= TO_NIGHT;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    TO_NIGHT: begin
                        if (is_lo) begin
                            if (cnt_inc == HOLD_CNT) begin
                                state        <= NIGHT;
                                cnt          <= '0;
                                day_q        <= 1'b0;
                                day_change_q <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= DAY;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= NIGHT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.day        = day_q;
    assign bus.day_change = day_change_q;

endmodule

// File: tb/tb_day_night_detector.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor compares every cycle.
module tb_day_night_detector;
    localparam int DATA_W  = 8;
    localparam int DAY_T   = 160;
    localparam int NIGHT_T = 96;
    localparam int HOLD    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    day_night_detector_if #(.DATA_W(DATA_W)) bus ();

`ifdef DAYNIGHT_FORCE_EN
    logic force_en  = 1'b0;
    logic force_day = 1'b0;
`endif

    day_night_detector #(
        .DATA_W(DATA_W), .DAY_THRESH(DAY_T), .NIGHT_THRESH(NIGHT_T),
        .HOLD_SAMPLES(HOLD), .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef DAYNIGHT_FORCE_EN
        .force_en(force_en),
        .force_day(force_day),
`endif
        .bus(bus)
    );

    typedef struct {
        logic  day;
        logic  chg;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "init";

    // Reference model: last four samples, a run length toward the opposite level, and the level.
    int win[4];
    int m_day;
    int m_run;

    task automatic step(input logic r, input logic v, input int s);
        exp_t e;
        int   avg;
        bit   toward;
        bit   chg;
        @(negedge clk);
        reset            = r;
        bus.sample_valid = v;
        bus.sample       = DATA_W'(s);
        chg = 1'b0;
        if (!r) begin
            for (int i = 0; i < 4; i++) win[i] = 0;
            m_day = 0;
            m_run = 0;
        end else if (v) begin
            win[3] = win[2];
            win[2] = win[1];
            win[1] = win[0];
            win[0] = s;
            avg = (win[0] + win[1] + win[2] + win[3]) / 4;
            toward = (m_day == 0) ? (avg >= DAY_T) : (avg <= NIGHT_T);
            if (toward) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_day = 1 - m_day;
                    m_run = 0;
                    chg   = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        e.day = (m_day != 0);
        e.chg = chg;
        e.tag = phase;
        exp_q.push_back(e);
    endtask

    task automatic samples(input int n, input int s, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, s);
            for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({bus.day, bus.day_change} !== {e.day, e.chg}) begin
                    miscompares++;
                    $display("FAIL %s @%0t: day/day_change got %b/%b expected %b/%b",
                             e.tag, $time, bus.day, bus.day_change, e.day, e.chg);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stim
        int level;
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;

        phase = "reset_hold";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        phase = "rise_back_to_back";
        samples(7, 200, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        phase = "mid_band_in_day";
        samples(20, 130, 0);

        phase = "aborted_fall";
        samples(4, 200, 0);
        samples(3, 0, 0);
        samples(2, 200, 0);
        step(1'b1, 1'b0, 0);

        phase = "reset_mid_debounce";
        step(1'b0, 1'b0, 0);
        samples(5, 200, 0);
        step(1'b0, 1'b0, 0);
        samples(7, 200, 0);
        step(1'b1, 1'b0, 0);

        phase = "rise_with_gaps";
        step(1'b0, 1'b0, 0);
        samples(7, 200, 3);
        step(1'b1, 1'b0, 0);

        phase = "full_fall";
        samples(8, 10, 1);

        phase = "random";
        level = 200;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: level = $urandom_range(0, 90);
                    1: level = $urandom_range(97, 159);
                    default: level = $urandom_range(161, 255);
                endcase
            end
            if ($urandom_range(0, 149) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            else if ($urandom_range(0, 9) < 7)
                step(1'b1, 1'b1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : level);
            else
                step(1'b1, 1'b0, int'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
